// File: rtl/ptp_offset_servo_if.sv
// Sample/correction bundle between the 1588 offset calculator, the offset servo
// and the local time counter.
interface ptp_offset_servo_if;
  // Valid-only protocol: each *_valid is a one-cycle pulse with no ready; a sample
  // that arrives while the servo is busy is dropped and reported on o_overrun.
  logic        i_delta_valid;
  logic [79:0] i_delta_t;
  logic        o_step_valid;
  logic [63:0] o_step_ns;
  logic        o_adj_valid;
  logic [31:0] o_freq_adj;
  logic        o_locked;
  logic        o_overrun;
  logic [1:0]  dbg_state;

  modport slave (
    input  i_delta_valid, i_delta_t,
    output o_step_valid, o_step_ns, o_adj_valid, o_freq_adj, o_locked, o_overrun,
    output dbg_state
  );

  modport master (
    output i_delta_valid, i_delta_t,
    input  o_step_valid, o_step_ns, o_adj_valid, o_freq_adj, o_locked, o_overrun,
    input  dbg_state
  );
endinterface

// File: rtl/ptp_offset_servo.sv
// Clock servo: turns offset samples into phase steps or PI rate corrections and
// tracks lock. Pipeline: capture, classify, arithmetic, output register.
module ptp_offset_servo #(
  parameter logic [63:0] STEP_THRESH_NS = 64'd1000,
  parameter logic [63:0] LOCK_THRESH_NS = 64'd100,
  parameter int unsigned LOCK_COUNT     = 8,
  parameter int unsigned SETTLE_SAMPLES = 2,
  parameter int unsigned KP_SHIFT       = 2,
  parameter int unsigned KI_SHIFT       = 4,
  parameter logic [47:0] INTEG_LIMIT    = 48'h0000_FFFF_FFFF
) (
  input logic               syc_clk_250m,
  input logic               sys_reset_n,
  ptp_offset_servo_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, SETTLE = 2'd2} state_t;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE_SAMPLES);
  localparam logic [7:0] LOCK_W   = 8'(LOCK_COUNT);
  localparam logic signed [50:0] MAX32 = 51'sh0_7FFF_FFFF;
  localparam logic signed [50:0] MIN32 = -51'sh0_8000_0000;

  state_t state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic v0, v1, v2, busy, accept, take, ovr_pend;
  logic [79:0] d0;
  logic signed [63:0] offset_ns;
  logic [63:0] abs_ns;
  logic signed [47:0] err;
  logic is_step, in_lock;
  logic s1_step, s1_lock_ok, s2_step, s2_lock_ok;
  logic signed [47:0] s1_err, integ_q, integ_new, ki_term, kp_term;
  logic [63:0] s1_step_ns, s2_step_ns;
  logic signed [48:0] integ_sum, lim_pos, lim_neg;
  logic signed [49:0] sum50;
  logic signed [50:0] sum_ext, neg_sum;
  logic [31:0] adj_sat, s2_adj;
  logic step_valid_q, adj_valid_q, locked_q, overrun_q;
  logic [63:0] step_ns_q;
  logic [31:0] freq_adj_q;
  logic [7:0] lock_cnt_q, lock_next;

  assign busy   = v0 | v1;
  assign accept = bus.i_delta_valid & ~busy;

  // Integer ns is a floor of the 2^-16 ns value; -2^63 maps to magnitude 2^63.
  assign offset_ns = d0[79:16];
  assign abs_ns    = offset_ns[63] ? (~offset_ns + 64'd1) : offset_ns;
  assign is_step   = abs_ns > STEP_THRESH_NS;
  assign in_lock   = abs_ns < LOCK_THRESH_NS;
  assign err = (d0[79:47] == {33{d0[79]}}) ? d0[47:0]
             : (d0[79] ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    take     = 1'b0;
    if (v0) begin
      if (state_q == SETTLE) begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) state_d = TRACK;
      end else begin
        take = 1'b1;
        if (is_step) begin
          settle_d = SETTLE_W;
          state_d  = (SETTLE_W == 4'd0) ? TRACK : SETTLE;
        end else begin
          state_d = TRACK;
        end
      end
    end
  end

  always_ff @(posedge syc_clk_250m) begin
    if (!sys_reset_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // PI arithmetic: integrator clamped in 49 bits, sum in 50, negated and saturated to 32.
  assign ki_term   = s1_err >>> KI_SHIFT;
  assign kp_term   = s1_err >>> KP_SHIFT;
  assign lim_pos   = {1'b0, INTEG_LIMIT};
  assign lim_neg   = -lim_pos;
  assign integ_sum = {integ_q[47], integ_q} + {ki_term[47], ki_term};

  always_comb begin
    integ_new = integ_sum[47:0];
    if (integ_sum > lim_pos)      integ_new = lim_pos[47:0];
    else if (integ_sum < lim_neg) integ_new = lim_neg[47:0];
  end

  assign sum50   = {{2{kp_term[47]}}, kp_term} + {{2{integ_new[47]}}, integ_new};
  assign sum_ext = {sum50[49], sum50};
  assign neg_sum = -sum_ext;

  always_comb begin
    adj_sat = neg_sum[31:0];
    if (neg_sum > MAX32)      adj_sat = 32'h7FFF_FFFF;
    else if (neg_sum < MIN32) adj_sat = 32'h8000_0000;
  end

  always_ff @(posedge syc_clk_250m) begin
    if (!sys_reset_n) begin
      v0 <= 1'b0; d0 <= '0;
      v1 <= 1'b0; s1_step <= 1'b0; s1_lock_ok <= 1'b0; s1_err <= '0; s1_step_ns <= '0;
      v2 <= 1'b0; s2_step <= 1'b0; s2_lock_ok <= 1'b0; s2_step_ns <= '0; s2_adj <= '0;
      integ_q <= '0; ovr_pend <= 1'b0;
    end else begin
      v0 <= accept;
      if (accept) d0 <= bus.i_delta_t;
      v1 <= take;
      if (take) begin
        s1_step    <= is_step;
        s1_lock_ok <= in_lock;
        s1_err     <= err;
        s1_step_ns <= -offset_ns;
      end
      v2 <= v1;
      if (v1) begin
        s2_step    <= s1_step;
        s2_lock_ok <= s1_lock_ok;
        s2_step_ns <= s1_step_ns;
        s2_adj     <= adj_sat;
        integ_q    <= s1_step ? '0 : integ_new;
      end
      ovr_pend <= bus.i_delta_valid & busy;
    end
  end

  assign lock_next = (lock_cnt_q == LOCK_W) ? lock_cnt_q : lock_cnt_q + 8'd1;

  always_ff @(posedge syc_clk_250m) begin
    if (!sys_reset_n) begin
      step_valid_q <= 1'b0; adj_valid_q <= 1'b0; step_ns_q <= '0; freq_adj_q <= '0;
      locked_q <= 1'b0; lock_cnt_q <= '0; overrun_q <= 1'b0;
    end else begin
      step_valid_q <= v2 & s2_step;
      adj_valid_q  <= v2 & ~s2_step;
      overrun_q    <= ovr_pend;
      if (v2 && s2_step) begin
        step_ns_q  <= s2_step_ns;
        lock_cnt_q <= '0;
        locked_q   <= 1'b0;
      end
      if (v2 && !s2_step) begin
        freq_adj_q <= s2_adj;
        if (s2_lock_ok) begin
          lock_cnt_q <= lock_next;
          locked_q   <= (lock_next == LOCK_W);
        end else begin
          lock_cnt_q <= '0;
          locked_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.o_step_valid = step_valid_q;
  assign bus.o_step_ns    = step_ns_q;
  assign bus.o_adj_valid  = adj_valid_q;
  assign bus.o_freq_adj   = freq_adj_q;
  assign bus.o_locked     = locked_q;
  assign bus.o_overrun    = overrun_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_ptp_offset_servo.sv
// Directed bench for ptp_offset_servo: default, small-integrator and
// huge-step-threshold instances driven from one linear sequence.
module tb_ptp_offset_servo;
  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic [79:0] in_delta;
  int          sel;
  int          total = 0;
  int          bad = 0;
  logic        exp_lk;

  ptp_offset_servo_if if_a ();
  ptp_offset_servo_if if_b ();
  ptp_offset_servo_if if_c ();

  assign if_a.i_delta_valid = in_valid && (sel == 0);
  assign if_b.i_delta_valid = in_valid && (sel == 1);
  assign if_c.i_delta_valid = in_valid && (sel == 2);
  assign if_a.i_delta_t = in_delta;
  assign if_b.i_delta_t = in_delta;
  assign if_c.i_delta_t = in_delta;

  ptp_offset_servo dut_a (.syc_clk_250m(clk), .sys_reset_n(rst_n), .bus(if_a.slave));
  ptp_offset_servo #(.INTEG_LIMIT(48'd1000)) dut_b (
    .syc_clk_250m(clk), .sys_reset_n(rst_n), .bus(if_b.slave));
  ptp_offset_servo #(.STEP_THRESH_NS(64'hFFFF_FFFF_FFFF_FFFF)) dut_c (
    .syc_clk_250m(clk), .sys_reset_n(rst_n), .bus(if_c.slave));

  logic        cur_step_valid, cur_adj_valid, cur_locked, cur_overrun;
  logic [63:0] cur_step_ns;
  logic [31:0] cur_freq_adj;

  always_comb begin
    cur_step_valid = if_a.o_step_valid; cur_adj_valid = if_a.o_adj_valid;
    cur_locked = if_a.o_locked; cur_overrun = if_a.o_overrun;
    cur_step_ns = if_a.o_step_ns; cur_freq_adj = if_a.o_freq_adj;
    if (sel == 1) begin
      cur_step_valid = if_b.o_step_valid; cur_adj_valid = if_b.o_adj_valid;
      cur_locked = if_b.o_locked; cur_overrun = if_b.o_overrun;
      cur_step_ns = if_b.o_step_ns; cur_freq_adj = if_b.o_freq_adj;
    end else if (sel == 2) begin
      cur_step_valid = if_c.o_step_valid; cur_adj_valid = if_c.o_adj_valid;
      cur_locked = if_c.o_locked; cur_overrun = if_c.o_overrun;
      cur_step_ns = if_c.o_step_ns; cur_freq_adj = if_c.o_freq_adj;
    end
  end

  function automatic logic [79:0] ns(input longint v);
    return {v, 16'h0000};
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [79:0] d);
    @(negedge clk);
    in_delta = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // kind: 0 no pulse (settle discard), 1 adj pulse, 2 step pulse, seen at N+3 only.
  task automatic expect_out(input string tag, input int kind, input logic lk_after);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i < 3) begin
        chk({tag, ":quiet_step"}, cur_step_valid, 0);
        chk({tag, ":quiet_adj"}, cur_adj_valid, 0);
        chk({tag, ":lock_hold"}, cur_locked, exp_lk);
      end else begin
        chk({tag, ":step_valid"}, cur_step_valid, (kind == 2) ? 1 : 0);
        chk({tag, ":adj_valid"}, cur_adj_valid, (kind == 1) ? 1 : 0);
        chk({tag, ":locked"}, cur_locked, lk_after);
      end
    end
    exp_lk = lk_after;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, ":step_valid"}, cur_step_valid, 0);
    chk({tag, ":step_ns"}, cur_step_ns, 0);
    chk({tag, ":adj_valid"}, cur_adj_valid, 0);
    chk({tag, ":freq_adj"}, $signed(cur_freq_adj), 0);
    chk({tag, ":locked"}, cur_locked, 0);
    chk({tag, ":overrun"}, cur_overrun, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_lk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_delta = '0; sel = 0; exp_lk = 1'b0;
    repeat (4) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // PI basic: 40 ns -> P 655360 + I 163840
    send(ns(40)); expect_out("pi1", 1, 0);
    chk("pi1_adj", $signed(cur_freq_adj), -819200);
    send(ns(40)); expect_out("pi2", 1, 0);
    chk("pi2_adj", $signed(cur_freq_adj), -983040);

    // Step 5000 ns, two settle discards, then adj from cleared integrator
    send(ns(5000)); expect_out("step", 2, 0);
    chk("step_ns", cur_step_ns, -5000);
    chk("step_adj_hold", $signed(cur_freq_adj), -983040);
    send(ns(40)); expect_out("settle1", 0, 0);
    send(ns(40)); expect_out("settle2", 0, 0);
    chk("settle_step_hold", cur_step_ns, -5000);
    send(ns(40)); expect_out("post_settle", 1, 0);
    chk("post_settle_adj", $signed(cur_freq_adj), -819200);

    // Lock acquisition and loss
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(ns(50)); expect_out("lock_a", 1, (i == 7));
    end
    send(ns(150)); expect_out("unlock150", 1, 0);
    for (int i = 0; i < 8; i++) begin
      send(ns(50)); expect_out("lock_b", 1, (i == 7));
    end
    send(ns(2000)); expect_out("step2000", 2, 0);
    chk("step2000_ns", cur_step_ns, -2000);
    send(ns(50)); expect_out("settle3", 0, 0);
    send(ns(50)); expect_out("settle4", 0, 0);

    // Boundaries
    send(ns(1000)); expect_out("thresh1000", 1, 0);
    send(ns(-1001)); expect_out("neg1001", 2, 0);
    chk("neg1001_ns", cur_step_ns, 1001);
    send(ns(50)); expect_out("settle5", 0, 0);
    send(ns(50)); expect_out("settle6", 0, 0);
    send({-64'sd1001, 16'h8000}); expect_out("neg1000p5", 2, 0);
    chk("neg1000p5_ns", cur_step_ns, 1001);
    send(ns(50)); expect_out("settle7", 0, 0);
    send(ns(50)); expect_out("settle8", 0, 0);
    for (int i = 0; i < 7; i++) begin
      send(ns(-50)); expect_out("pre100", 1, 0);
    end
    send(ns(100)); expect_out("exact100", 1, 0);
    send(ns(50)); expect_out("after100", 1, 0);
    for (int i = 0; i < 7; i++) begin
      send(ns(50)); expect_out("relock", 1, (i == 6));
    end

    // Overrun: valid at N and N+1
    @(negedge clk); in_delta = ns(40); in_valid = 1'b1;
    @(negedge clk);
    chk("ovr_n0", cur_overrun, 0);
    @(negedge clk); in_valid = 1'b0;
    chk("ovr_n1", cur_overrun, 0);
    chk("ovr_n1_adj", cur_adj_valid, 0);
    @(negedge clk);
    chk("ovr_n2", cur_overrun, 1);
    chk("ovr_n2_adj", cur_adj_valid, 0);
    @(negedge clk);
    chk("ovr_n3_adj", cur_adj_valid, 1);
    chk("ovr_n3_ovr", cur_overrun, 0);
    chk("ovr_n3_locked", cur_locked, 1);
    @(negedge clk);
    chk("ovr_n4_adj", cur_adj_valid, 0);

    // Reset while a sample is in flight
    send(ns(40));
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("mid_reset");
    rst_n = 1'b1; exp_lk = 1'b0;
    @(negedge clk);
    chk("mid_reset_no_pulse", cur_adj_valid, 0);
    send(ns(40)); expect_out("after_reset", 1, 0);
    chk("after_reset_adj", $signed(cur_freq_adj), -819200);

    // Integrator saturation at 1000
    sel = 1; exp_lk = 1'b0;
    send(ns(900)); expect_out("sat_first", 1, 0);
    chk("sat_first_adj", $signed(cur_freq_adj), -14746600);
    for (int i = 0; i < 99; i++) begin
      send(ns(900)); expect_out("sat_run", 1, 0);
    end
    chk("sat_last_adj", $signed(cur_freq_adj), -14746600);
    send(ns(-900)); expect_out("sat_neg", 1, 0);
    chk("sat_neg_adj", $signed(cur_freq_adj), 14746600);

    // 32-bit output saturation with extreme inputs on the PI path
    sel = 2; exp_lk = 1'b0;
    send({1'b0, {79{1'b1}}}); expect_out("max_in", 1, 0);
    chk("max_in_adj", $signed(cur_freq_adj), -64'sd2147483648);
    send({1'b1, 79'd0}); expect_out("min_in", 1, 0);
    chk("min_in_adj", $signed(cur_freq_adj), 64'sd2147483647);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
